game_flow_controller: RTL and testbench

- Top-level game sequencer for the Frogger design: owns lives, level and game phase (idle/play/hit/level-up/game-over).
- Consumes collision and crossing events from the frog and collision logic and a per-frame tick from the VGA timing.
- Drives frog-respawn pulses, a global freeze for obstacle and frog motion, and the per-level car step period used by every obstacle lane.

---
 rtl/game_flow_controller_pkg.sv | 20 ++
 rtl/game_flow_controller_if.sv | 23 ++
 rtl/game_flow_controller_speed_table.sv | 36 +++
 rtl/game_flow_controller.sv | 122 ++++++++++++
 tb/tb_game_flow_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared constants and state encoding for the Frogger game sequencer.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam logic [2:0]  c_LIVES_INI      = 3'd3;
    localparam logic [3:0]  c_LEVEL_MAX      = 4'd8;
    localparam int          c_HIT_FRAMES     = 60;
    localparam int          c_LEVELUP_FRAMES = 30;
    localparam logic [19:0] c_BASE_PERIOD    = 20'd600000;
    localparam logic [19:0] c_PERIOD_STEP    = 20'd60000;
    localparam logic [19:0] c_MIN_PERIOD     = 20'd150000;

endpackage

// File: rtl/game_flow_controller_if.sv
// Event inputs and control outputs of the game sequencer.
interface game_flow_controller_if;
    logic        i_Start;
    logic        i_Frame_Tick;
    logic        i_Has_Collided;
    logic        i_Frog_Crossed;
    logic [2:0]  o_State;
    logic [2:0]  o_Lives;
    logic [3:0]  o_Level;
    logic [19:0] o_Car_Period;
    logic        o_Freeze;
    logic        o_Frog_Respawn;

    modport master (
        input  i_Start, i_Frame_Tick, i_Has_Collided, i_Frog_Crossed,
        output o_State, o_Lives, o_Level, o_Car_Period, o_Freeze, o_Frog_Respawn
    );

    modport slave (
        output i_Start, i_Frame_Tick, i_Has_Collided, i_Frog_Crossed,
        input  o_State, o_Lives, o_Level, o_Car_Period, o_Freeze, o_Frog_Respawn
    );
endinterface

// File: rtl/game_flow_controller_speed_table.sv
// Level to car step period: linear reduction per level, floored, registered.
module game_flow_controller_speed_table
    import game_flow_controller_pkg::*;
#(
    parameter logic [19:0] P_BASE_PERIOD = c_BASE_PERIOD,
    parameter logic [19:0] P_PERIOD_STEP = c_PERIOD_STEP,
    parameter logic [19:0] P_MIN_PERIOD  = c_MIN_PERIOD
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [3:0]  i_Level,
    output logic [19:0] o_Car_Period
);

    logic [23:0] prod;
    logic [23:0] headroom;
    logic [23:0] diff;
    logic [19:0] period_d;
    logic [19:0] period_q;

    // Clamp before subtracting so the 24-bit difference can never wrap.
    always_comb begin
        prod     = 24'(i_Level - 4'd1) * 24'(P_PERIOD_STEP);
        headroom = 24'(P_BASE_PERIOD) - 24'(P_MIN_PERIOD);
        diff     = 24'(P_BASE_PERIOD) - prod;
        period_d = (prod >= headroom) ? P_MIN_PERIOD : diff[19:0];
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) period_q <= P_BASE_PERIOD;
        else         period_q <= period_d;
    end

    assign o_Car_Period = period_q;

endmodule

// File: rtl/game_flow_controller.sv
// Frogger game sequencer: lives, level, phase, freeze and frog respawn.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter logic [2:0]  P_LIVES_INI      = c_LIVES_INI,
    parameter logic [3:0]  P_LEVEL_MAX      = c_LEVEL_MAX,
    parameter int          P_HIT_FRAMES     = c_HIT_FRAMES,
    parameter int          P_LEVELUP_FRAMES = c_LEVELUP_FRAMES,
    parameter logic [19:0] P_BASE_PERIOD    = c_BASE_PERIOD,
    parameter logic [19:0] P_PERIOD_STEP    = c_PERIOD_STEP,
    parameter logic [19:0] P_MIN_PERIOD     = c_MIN_PERIOD
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    game_flow_controller_if.master bus
);

    localparam logic [7:0] HIT_LAST = 8'(P_HIT_FRAMES - 1);
    localparam logic [7:0] LUP_LAST = 8'(P_LEVELUP_FRAMES - 1);

    state_e     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic [7:0] timer_q, timer_d;
    logic       freeze_q, freeze_d;
    logic       respawn_q, respawn_d;
    logic       start_q;
    logic       start_edge;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= P_LIVES_INI;
            level_q   <= 4'd1;
            timer_q   <= 8'd0;
            freeze_q  <= 1'b1;
            respawn_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            timer_q   <= timer_d;
            freeze_q  <= freeze_d;
            respawn_q <= respawn_d;
            start_q   <= bus.i_Start;
        end
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        timer_d    = timer_q;
        start_edge = bus.i_Start & ~start_q;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge) begin
                    lives_d = P_LIVES_INI;
                    level_d = 4'd1;
                    timer_d = 8'd0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A collision wins over a crossing in the same cycle.
                if (bus.i_Has_Collided) begin
                    lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                    timer_d = 8'd0;
                    state_d = ST_HIT;
                end else if (bus.i_Frog_Crossed) begin
                    if (level_q != P_LEVEL_MAX) level_d = level_q + 4'd1;
                    timer_d = 8'd0;
                    state_d = ST_LEVEL_UP;
                end
            end
            ST_HIT: begin
                if (bus.i_Frame_Tick) begin
                    if (timer_q == HIT_LAST) begin
                        timer_d = 8'd0;
                        state_d = (lives_q == 3'd0) ? ST_GAME_OVER : ST_PLAY;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            ST_LEVEL_UP: begin
                if (bus.i_Frame_Tick) begin
                    if (timer_q == LUP_LAST) begin
                        timer_d = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        freeze_d  = (state_d != ST_PLAY);
        respawn_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    end

    game_flow_controller_speed_table #(
        .P_BASE_PERIOD (P_BASE_PERIOD),
        .P_PERIOD_STEP (P_PERIOD_STEP),
        .P_MIN_PERIOD  (P_MIN_PERIOD)
    ) u_speed_table (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Level      (level_q),
        .o_Car_Period (bus.o_Car_Period)
    );

    assign bus.o_State        = state_q;
    assign bus.o_Lives        = lives_q;
    assign bus.o_Level        = level_q;
    assign bus.o_Freeze       = freeze_q;
    assign bus.o_Frog_Respawn = respawn_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller; a second instance uses a larger period step.
module tb_game_flow_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   resp_cnt = 0;

    always #5 clk = ~clk;

    game_flow_controller_if bus ();
    game_flow_controller_if bus2 ();

    game_flow_controller dut (.i_Clk(clk), .i_Reset(rst), .bus(bus));

    game_flow_controller #(.P_PERIOD_STEP(20'd100000)) dut2 (.i_Clk(clk), .i_Reset(rst), .bus(bus2));

    assign bus2.i_Start        = bus.i_Start;
    assign bus2.i_Frame_Tick   = bus.i_Frame_Tick;
    assign bus2.i_Has_Collided = bus.i_Has_Collided;
    assign bus2.i_Frog_Crossed = bus.i_Frog_Crossed;

    always @(negedge clk) if (bus.o_Frog_Respawn === 1'b1) resp_cnt++;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_Frame_Tick = 1'b1;
            step();
            bus.i_Frame_Tick = 1'b0;
            step();
        end
    endtask

    task automatic pulse_collide();
        bus.i_Has_Collided = 1'b1;
        step();
        bus.i_Has_Collided = 1'b0;
    endtask

    task automatic pulse_cross();
        bus.i_Frog_Crossed = 1'b1;
        step();
        bus.i_Frog_Crossed = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step();
    endtask

    task automatic start_game();
        bus.i_Start = 1'b1;
        step(2);
        bus.i_Start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.o_State !== 3'd0 || bus.o_Lives !== 3'd3 || bus.o_Level !== 4'd1 ||
            bus.o_Car_Period !== 20'd600000 || bus.o_Freeze !== 1'b1 || bus.o_Frog_Respawn !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: st=%0d lives=%0d lvl=%0d per=%0d frz=%b rsp=%b, need 0/3/1/600000/1/0",
                     bus.o_State, bus.o_Lives, bus.o_Level, bus.o_Car_Period, bus.o_Freeze, bus.o_Frog_Respawn);
        end
        step(3);
        checks++;
        if (bus.o_State !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: state=%0d need 0", bus.o_State);
        end
    endtask

    task automatic test_start();
        int r0;
        r0 = resp_cnt;
        start_game();
        checks++;
        if (resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL start_respawn: pulses=%0d need 1", resp_cnt - r0);
        end
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Lives !== 3'd3 || bus.o_Level !== 4'd1 ||
            bus.o_Car_Period !== 20'd600000 || bus.o_Freeze !== 1'b0) begin
            errors++;
            $display("FAIL start_play: st=%0d lives=%0d lvl=%0d per=%0d frz=%b, need 1/3/1/600000/0",
                     bus.o_State, bus.o_Lives, bus.o_Level, bus.o_Car_Period, bus.o_Freeze);
        end
    endtask

    task automatic test_hit();
        int r0;
        pulse_collide();
        checks++;
        if (bus.o_State !== 3'd2 || bus.o_Lives !== 3'd2 || bus.o_Freeze !== 1'b1) begin
            errors++;
            $display("FAIL hit_enter: st=%0d lives=%0d frz=%b, need 2/2/1", bus.o_State, bus.o_Lives, bus.o_Freeze);
        end
        r0 = resp_cnt;
        tick(59);
        checks++;
        if (bus.o_State !== 3'd2 || resp_cnt != r0) begin
            errors++;
            $display("FAIL hit_59_ticks: st=%0d pulses=%0d, need 2/0", bus.o_State, resp_cnt - r0);
        end
        tick(1);
        checks++;
        if (bus.o_State !== 3'd1 || resp_cnt - r0 !== 1 || bus.o_Freeze !== 1'b0) begin
            errors++;
            $display("FAIL hit_exit: st=%0d pulses=%0d frz=%b, need 1/1/0", bus.o_State, resp_cnt - r0, bus.o_Freeze);
        end
    endtask

    task automatic test_game_over();
        int r0;
        do_reset();
        start_game();
        pulse_collide();
        tick(60);
        pulse_collide();
        tick(60);
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Lives !== 3'd1) begin
            errors++;
            $display("FAIL two_hits: st=%0d lives=%0d, need 1/1", bus.o_State, bus.o_Lives);
        end
        pulse_collide();
        r0 = resp_cnt;
        bus.i_Start = 1'b1;
        tick(60);
        step(4);
        checks++;
        if (bus.o_State !== 3'd4 || bus.o_Lives !== 3'd0 || resp_cnt != r0 || bus.o_Freeze !== 1'b1) begin
            errors++;
            $display("FAIL game_over: st=%0d lives=%0d pulses=%0d frz=%b, need 4/0/0/1",
                     bus.o_State, bus.o_Lives, resp_cnt - r0, bus.o_Freeze);
        end
        bus.i_Start = 1'b0;
        step();
        r0 = resp_cnt;
        start_game();
        checks++;
        if (bus.o_State !== 3'd1 || bus.o_Lives !== 3'd3 || bus.o_Level !== 4'd1 || resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL restart: st=%0d lives=%0d lvl=%0d pulses=%0d, need 1/3/1/1",
                     bus.o_State, bus.o_Lives, bus.o_Level, resp_cnt - r0);
        end
    endtask

    task automatic test_levels();
        logic [19:0] exp_per [0:8];
        logic [19:0] exp_per2[0:8];
        logic [3:0]  exp_lvl;
        exp_per  = '{20'd540000, 20'd480000, 20'd420000, 20'd360000, 20'd300000,
                     20'd240000, 20'd180000, 20'd180000, 20'd180000};
        exp_per2 = '{20'd500000, 20'd400000, 20'd300000, 20'd200000, 20'd150000,
                     20'd150000, 20'd150000, 20'd150000, 20'd150000};
        for (int k = 0; k < 9; k++) begin
            exp_lvl = (k < 7) ? 4'(k + 2) : 4'd8;
            pulse_cross();
            checks++;
            if (bus.o_State !== 3'd3 || bus.o_Freeze !== 1'b1 || bus.o_Level !== exp_lvl) begin
                errors++;
                $display("FAIL levelup_enter_%0d: st=%0d frz=%b lvl=%0d, need 3/1/%0d",
                         k, bus.o_State, bus.o_Freeze, bus.o_Level, exp_lvl);
            end
            tick(30);
            checks++;
            if (bus.o_State !== 3'd1 || bus.o_Car_Period !== exp_per[k] || bus2.o_Car_Period !== exp_per2[k]) begin
                errors++;
                $display("FAIL level_%0d: st=%0d per=%0d per_step100k=%0d, need 1/%0d/%0d",
                         k, bus.o_State, bus.o_Car_Period, bus2.o_Car_Period, exp_per[k], exp_per2[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bus.i_Has_Collided = 1'b1;
        bus.i_Frog_Crossed = 1'b1;
        step();
        bus.i_Has_Collided = 1'b0;
        bus.i_Frog_Crossed = 1'b0;
        checks++;
        if (bus.o_State !== 3'd2 || bus.o_Lives !== 3'd2 || bus.o_Level !== 4'd8) begin
            errors++;
            $display("FAIL collide_and_cross: st=%0d lives=%0d lvl=%0d, need 2/2/8",
                     bus.o_State, bus.o_Lives, bus.o_Level);
        end
    endtask

    task automatic test_reset_mid_hit();
        int r0;
        tick(20);
        r0 = resp_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_State !== 3'd0 || bus.o_Lives !== 3'd3 || bus.o_Level !== 4'd1 ||
            bus.o_Car_Period !== 20'd600000 || bus.o_Freeze !== 1'b1 || bus.o_Frog_Respawn !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hit: st=%0d lives=%0d lvl=%0d per=%0d frz=%b rsp=%b, need 0/3/1/600000/1/0",
                     bus.o_State, bus.o_Lives, bus.o_Level, bus.o_Car_Period, bus.o_Freeze, bus.o_Frog_Respawn);
        end
        step(2);
        rst = 1'b0;
        step(3);
        checks++;
        if (bus.o_State !== 3'd0 || resp_cnt != r0) begin
            errors++;
            $display("FAIL after_reset_idle: st=%0d pulses=%0d, need 0/0", bus.o_State, resp_cnt - r0);
        end
    endtask

    task automatic test_held_collision();
        int r0;
        start_game();
        bus.i_Has_Collided = 1'b1;
        step();
        r0 = resp_cnt;
        tick(60);
        step();
        checks++;
        if (bus.o_State !== 3'd2 || bus.o_Lives !== 3'd1 || resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL held_collision: st=%0d lives=%0d pulses=%0d, need 2/1/1",
                     bus.o_State, bus.o_Lives, resp_cnt - r0);
        end
        bus.i_Has_Collided = 1'b0;
    endtask

    initial begin
        bus.i_Start        = 1'b0;
        bus.i_Frame_Tick   = 1'b0;
        bus.i_Has_Collided = 1'b0;
        bus.i_Frog_Crossed = 1'b0;
        test_reset();
        test_start();
        test_hit();
        test_game_over();
        test_levels();
        test_simultaneous();
        test_reset_mid_hit();
        test_held_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
